// File: rtl/trng_uart_rx.sv
// UART 8N1 receiver for the TRNG byte stream.
// Bytes are delivered through a one-deep valid/ready holding register.
// Framing errors and overruns are flagged with one-cycle pulses.
// block_done marks the last byte of each hash block.
module trng_uart_rx #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int BYTES_PER_BLOCK = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       block_done
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int BLK_W    = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BYTES_PER_BLOCK - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // Synchronizer flops, preset to the idle line level
    logic             rx_meta_q;
    logic             rx_s_q;

    // Receive FSM state
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       bit_q,    bit_d;
    logic [7:0]       shift_q,  shift_d;

    // Holding register, block counter and status pulses
    logic [7:0]       data_q,   data_d;
    logic             valid_q,  valid_d;
    logic             ferr_q,   ferr_d;
    logic             ovr_q,    ovr_d;
    logic             bdone_q,  bdone_d;
    logic [BLK_W-1:0] blk_q,    blk_d;

    // Per-cycle events from the FSM
    logic             byte_done;
    logic             stop_bad;
    logic             load;

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // FSM next state: cnt holds the cycle index within the current bit,
    // so cnt == k in the k-th cycle after the falling edge was seen
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = CNT_ONE;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = CNT_ONE;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = CNT_ONE;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    if (rx_s_q) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding register, handshake, overrun and block accounting
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        blk_d   = blk_q;
        bdone_d = 1'b0;
        ferr_d  = stop_bad;
        ovr_d   = byte_done && valid_q && !rx_ready;
        load    = byte_done && (!valid_q || rx_ready);

        if (load) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (blk_q == BLK_LAST) begin
                blk_d   = '0;
                bdone_d = 1'b1;
            end else begin
                blk_d = blk_q + BLK_W'(1);
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            bdone_q <= 1'b0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            bdone_q <= bdone_d;
            blk_q   <= blk_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign block_done = bdone_q;

endmodule
